// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit 7-segment display: steps the digit mux select,
// blanks the anodes at the start of each slot and registers seg/an onto the pins.
module seg7_scan_ctrl #(
    parameter int unsigned DIV_WIDTH    = 16,
    parameter int unsigned DIV_MAX      = 49999,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit_en,
    input  logic [7:0] mux_data,
    output logic [1:0] mux_sel,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam logic [DIV_WIDTH-1:0] CNT_MAX   = DIV_WIDTH'(DIV_MAX);
    localparam logic [DIV_WIDTH-1:0] BLANK_LIM = DIV_WIDTH'(BLANK_CYCLES);
    localparam logic [7:0]           SEG_OFF   = ACTIVE_LOW ? 8'hFF : 8'h00;

    if (BLANK_CYCLES > DIV_MAX) begin : g_bad_blank
        $error("seg7_scan_ctrl: BLANK_CYCLES (%0d) exceeds DIV_MAX (%0d)", BLANK_CYCLES, DIV_MAX);
    end

    logic [DIV_WIDTH-1:0] cnt;
    logic                 slot_end;
    logic                 show;
    logic                 lit;
    logic [7:0]           seg_on;

    assign slot_end = (cnt == CNT_MAX);
    // A zero-length blank phase leaves every count in SHOW.
    assign show     = (BLANK_CYCLES == 0) || (cnt >= BLANK_LIM);
    assign lit      = en && show && digit_en[mux_sel];
    assign seg_on   = ACTIVE_LOW ? ~mux_data : mux_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            mux_sel <= '0;
        end else if (en) begin
            if (slot_end) begin
                cnt     <= '0;
                mux_sel <= mux_sel + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= 4'b1111;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= lit ? ~(4'b0001 << mux_sel) : 4'b1111;
            seg        <= lit ? seg_on : SEG_OFF;
            frame_tick <= en && (mux_sel == 2'd3) && slot_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with a behavioural 4:1 digit mux upstream.
module tb_seg7_scan_ctrl;

    localparam int unsigned DIV_MAX = 9;
    localparam int unsigned BLANK   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] digit_en;
    logic [7:0] mux_data;
    logic [1:0] mux_sel;
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame_tick;

    logic [7:0] digits [4];

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic [1:0] sel;
        logic       ft;
    } exp_t;

    exp_t sb[$];

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned ft_count;
    int unsigned m_cnt;
    logic [1:0]  m_sel;

    always #5 clk = ~clk;

    assign mux_data = digits[mux_sel];

    seg7_scan_ctrl #(
        .DIV_WIDTH   (8),
        .DIV_MAX     (DIV_MAX),
        .BLANK_CYCLES(BLANK),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digit_en  (digit_en),
        .mux_data  (mux_data),
        .mux_sel   (mux_sel),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with inputs settled; predicts the next edge, then compares.
    task automatic step();
        exp_t e;
        logic lit;
        lit   = en && (m_cnt >= BLANK) && digit_en[m_sel];
        e.an  = lit ? ~(4'b0001 << m_sel) : 4'b1111;
        e.seg = lit ? ~digits[m_sel] : 8'hFF;
        e.ft  = en && (m_sel == 2'd3) && (m_cnt == DIV_MAX);
        if (en) begin
            if (m_cnt == DIV_MAX) begin
                m_cnt = 0;
                m_sel = m_sel + 2'd1;
            end else begin
                m_cnt++;
            end
        end
        e.sel = m_sel;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("an", 32'(an), 32'(e.an));
        check("seg", 32'(seg), 32'(e.seg));
        check("mux_sel", 32'(mux_sel), 32'(e.sel));
        check("frame_tick", 32'(frame_tick), 32'(e.ft));
        if (frame_tick) ft_count++;
        @(negedge clk);
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    // Advance until the model reaches the given slot/count, bounded.
    task automatic run_to(input logic [1:0] sel, input int unsigned cnt);
        int unsigned guard = 0;
        while (!(m_sel == sel && m_cnt == cnt) && guard < 100) begin
            step();
            guard++;
        end
        check("run_to_bound", 32'(guard < 100), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        digits[0] = 8'h3F;
        digits[1] = 8'h06;
        digits[2] = 8'h5B;
        digits[3] = 8'h4F;
        rst_n    = 1'b0;
        en       = 1'b0;
        digit_en = 4'hF;
        m_cnt    = 0;
        m_sel    = 2'd0;
        ft_count = 0;

        @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_sel", 32'(mux_sel), 32'h0);
        check("rst_ft", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Plain scan: first blank cycles, then digit 0 and digit 1 patterns.
        run(2);
        check("scan_blank", 32'(an), 32'hF);
        run(1);
        check("scan_d0_an", 32'(an), 32'hE);
        check("scan_d0_seg", 32'(seg), 32'hC0);
        run(10);
        check("scan_d1_an", 32'(an), 32'hD);
        check("scan_d1_seg", 32'(seg), 32'hF9);
        run(10);
        check("scan_d2_seg", 32'(seg), 32'hA4);
        run(10);
        check("scan_d3_an", 32'(an), 32'h7);
        check("scan_d3_seg", 32'(seg), 32'hB0);
        run(4);

        // Asynchronous reset between edges, mid-scan.
        run_to(2'd1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_an", 32'(an), 32'hF);
        check("arst_seg", 32'(seg), 32'hFF);
        check("arst_sel", 32'(mux_sel), 32'h0);
        check("arst_ft", 32'(frame_tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        m_sel = 2'd0;

        // Masked digits over three frames; frame period must stay 40 cycles.
        digit_en = 4'b0101;
        ft_count = 0;
        run(15);
        check("mask_d1_an", 32'(an), 32'hF);
        check("mask_d1_seg", 32'(seg), 32'hFF);
        run(105);
        check("frame_ticks", ft_count, 32'd3);

        // Freeze in the middle of digit 2.
        digit_en = 4'hF;
        run_to(2'd2, 5);
        en = 1'b0;
        run(7);
        check("frz_sel", 32'(mux_sel), 32'h2);
        check("frz_an", 32'(an), 32'hF);
        en = 1'b1;
        run(1);
        check("resume_an", 32'(an), 32'hB);
        check("resume_seg", 32'(seg), 32'hA4);
        run(4);

        // Live data change during digit 1 SHOW phase.
        run_to(2'd1, 4);
        check("live_before", 32'(seg), 32'hF9);
        digits[1] = 8'h7F;
        run(1);
        check("live_seg", 32'(seg), 32'h80);
        check("live_an", 32'(an), 32'hD);
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
